dmx_tx: RTL
===========

# dmx_tx

DMX512 transmit serializer, directly downstream of the 250 kHz clock-enable generator. The generator produces a one-CLK-wide enable pulse every 16 cycles of the 4 MHz CLK. On request, this block sends one complete DMX512 packet at 4 µs per bit:

- BREAK
- MARK-AFTER-BREAK
- start code
- NUM_SLOTS data slots, fetched from the channel memory through a simple address/data port

TX drives the line driver.

## Interface
- NUM_SLOTS, 512: data slots per packet, legal range 1..512.
- BREAK_BITS, 23: BREAK length in bit-times (92 µs at 4 µs per bit).
- MAB_BITS, 3: MARK-AFTER-BREAK length in bit-times (12 µs).
- START_CODE, 8'h00: value sent in slot 0.

- CLK  in  1  system clock, 4 MHz.
- RST  in  1  reset, asynchronous, active-low.
- CLK_EN  in  1  bit-rate enable, one CLK wide, once every 16 CLK.
- START  in  1  packet request, level or pulse, sampled on every CLK.
- SLOT_ADDR  out  9  channel-memory address (slot number − 1).
- SLOT_DATA  in  8  channel-memory read data.
- TX  out  1  serial line, idle/mark = 1.
- BUSY  out  1  high from START capture until packet end.
- DONE  out  1  one-CLK pulse when the final stop bit completes.

## Operation
- States: IDLE, BREAK, MAB, FRAME. All outputs are registered.
- State and bit advances happen only on a CLK rising edge with CLK_EN=1. When CLK_EN is low, everything holds, except START capture.
- IDLE: TX=1.
  - START=1 while not busy sets the internal flag `pend` on that CLK edge.
  - The next CLK_EN with `pend`=1 enters BREAK and clears `pend`.
- START while BUSY=1 is ignored; it is not queued.
- BREAK: TX=0 for BREAK_BITS enables, then MAB.
- MAB: TX=1 for MAB_BITS enables, then FRAME with slot index s=0.
- FRAME: 11 bit-times per slot, LSB first.
  - Start bit: 0.
  - D0..D7.
  - Two stop bits: 1.
  - Bit counter runs 0..10.
  - No inter-slot mark time: the next start bit follows the second stop bit immediately.
- Data source:
  - Slot 0 sends START_CODE.
  - Slot s≥1 sends memory word s−1.
- SLOT_ADDR = s−1 for s≥1.
  - Updated on the enable that begins the slot's start bit.
  - Held constant for the whole frame.
  - For slot 0 it is 0.
- SLOT_DATA is latched into the shift register on the enable that ends the start bit. The memory therefore gets ≥15 CLK of read latency.
- End of packet: the enable ending the second stop bit of slot NUM_SLOTS does all of the following on the same edge:
  - returns to IDLE;
  - pulses DONE for 1 CLK;
  - drops BUSY.
- BUSY = (state≠IDLE) | `pend`.
- Slot index width is 10 bits. It compares against NUM_SLOTS and never wraps within a packet.

## Timing
- Reset values: TX=1, BUSY=0, DONE=0, SLOT_ADDR=0, `pend`=0, state IDLE.
- Reset mid-packet takes effect immediately, which aborts the packet. After release, no START is needed to block output: the block stays idle until a fresh START.
- Latency from START capture to TX falling is the wait for the next CLK_EN, 1..16 CLK.
- The TX change aligns with the CLK_EN edge: TX changes on the same edge that samples CLK_EN=1.
- Packet duration, in bit-times: BREAK_BITS + MAB_BITS + 11·(NUM_SLOTS+1).
  - Defaults: 23 + 3 + 5643 = 5669 bit-times = 22 676 µs.
- START and CLK_EN on the same edge while in IDLE: `pend` is set on that edge. BREAK begins at the following enable, not the current one.
- START asserted on the DONE edge is ignored, because BUSY is still high on that edge. START must be seen on a later edge.
- Back-to-back packets:
  - Minimum idle time between packets is 1 enable interval.
  - TX stays 1 between packets.

## Test plan
- Reset, then NUM_SLOTS=4 with memory {8'hA5, 8'h3C, 8'hFF, 8'h01}, one-CLK START pulse. Required response:
  - TX low for 23 enables, then high for 3.
  - Then frames for 0x00, A5, 3C, FF, 01, each as 0 / LSB-first data / 1 1.
  - DONE is one pulse after 81 enables.
  - BUSY falls on the same edge as DONE.
- Memory with a 1-CLK read latency, returning the data for address k as k+8'h10. Required response:
  - SLOT_ADDR steps 0,1,2,3.
  - Each address is stable across its 11 bit-times.
  - Decoded slots are 10,11,12,13.
- START held high for 3 enables, and START pulsed mid-packet. Required response: exactly one packet; no second BREAK after DONE.
- RST asserted during the slot-2 data bits. Required response:
  - TX=1, BUSY=0, DONE=0 immediately.
  - After release, TX stays 1 for 100 enables with no START.
- CLK_EN held low for 40 CLK mid-BREAK. Required response:
  - TX and SLOT_ADDR frozen.
  - BREAK still totals exactly 23 enables.
- Default parameters, NUM_SLOTS=512. Required response:
  - DONE occurs 5669 enables after BREAK starts.
  - Last SLOT_ADDR is 511.
  - Second stop bit is 1.

Source files
------------

// File: rtl/dmx_tx_if.sv
// Signal bundle between the DMX512 serializer and its enable source,
// channel memory and line driver.
interface dmx_tx_if;
    logic       CLK_EN;
    logic       START;
    logic [8:0] SLOT_ADDR;
    logic [7:0] SLOT_DATA;
    logic       TX;
    logic       BUSY;
    logic       DONE;

    modport master (
        input  CLK_EN, START, SLOT_DATA,
        output SLOT_ADDR, TX, BUSY, DONE
    );

    modport slave (
        output CLK_EN, START, SLOT_DATA,
        input  SLOT_ADDR, TX, BUSY, DONE
    );
endinterface

// File: rtl/dmx_tx.sv
// DMX512 packet serializer: BREAK, MARK-AFTER-BREAK, start code and
// NUM_SLOTS data slots at one bit per CLK_EN, 8N2 LSB first.
module dmx_tx #(
    parameter int unsigned NUM_SLOTS  = 512,
    parameter int unsigned BREAK_BITS = 23,
    parameter int unsigned MAB_BITS   = 3,
    parameter logic [7:0]  START_CODE = 8'h00
) (
    input  logic     CLK,
    input  logic     RST,
    dmx_tx_if.master dmx
);
    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAB, S_FRAME} state_t;

    localparam int unsigned   CW         = 16;
    localparam logic [CW-1:0] BREAK_LAST = CW'(BREAK_BITS - 1);
    localparam logic [CW-1:0] MAB_LAST   = CW'(MAB_BITS - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(10);
    localparam logic [9:0]    LAST_SLOT  = 10'(NUM_SLOTS);

    state_t        state;
    logic          pend;
    logic [CW-1:0] cnt;
    logic [9:0]    slot;
    logic [7:0]    shreg;
    logic [7:0]    first_byte;
    logic [8:0]    slot_addr;
    logic          tx;
    logic          busy;
    logic          done;

    assign first_byte    = (slot == '0) ? START_CODE : dmx.SLOT_DATA;
    assign dmx.SLOT_ADDR = slot_addr;
    assign dmx.TX        = tx;
    assign dmx.BUSY      = busy;
    assign dmx.DONE      = done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            pend      <= 1'b0;
            cnt       <= '0;
            slot      <= '0;
            shreg     <= '1;
            slot_addr <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            // Request capture runs every CLK; busy already covers pend.
            if (dmx.START && !busy) begin
                pend <= 1'b1;
                busy <= 1'b1;
            end

            if (dmx.CLK_EN) begin
                unique case (state)
                    S_IDLE: begin
                        if (pend) begin
                            state <= S_BREAK;
                            pend  <= 1'b0;
                            tx    <= 1'b0;
                            cnt   <= '0;
                        end
                    end
                    S_BREAK: begin
                        if (cnt == BREAK_LAST) begin
                            state <= S_MAB;
                            tx    <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_MAB: begin
                        if (cnt == MAB_LAST) begin
                            state     <= S_FRAME;
                            tx        <= 1'b0;
                            cnt       <= '0;
                            slot      <= '0;
                            slot_addr <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_FRAME: begin
                        // Ones shift in from the top so the stop bits fall out for free.
                        if (cnt == '0) begin
                            tx    <= first_byte[0];
                            shreg <= {1'b1, first_byte[7:1]};
                            cnt   <= cnt + 1'b1;
                        end else if (cnt != BIT_LAST) begin
                            tx    <= shreg[0];
                            shreg <= {1'b1, shreg[7:1]};
                            cnt   <= cnt + 1'b1;
                        end else if (slot == LAST_SLOT) begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            slot      <= slot + 1'b1;
                            slot_addr <= slot[8:0];
                            tx        <= 1'b0;
                            cnt       <= '0;
                        end
                    end
                endcase
            end
        end
    end
endmodule
